// File: rtl/axi_rd_outstanding_limiter.sv
// axi_rd_outstanding_limiter
//
// Read-channel stage between the prefetcher's memory-side AXI master and the
// DRAM slave. AR requests pass through one register slice (bypass-on-drain)
// and are only accepted while fewer than 2**LOG_MAX_OUTSTANDING bursts are in
// flight. R beats are wired straight through. Every returned burst is checked
// against the length recorded when its AR was accepted, and protocol
// violations are latched in a sticky error code.
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   en                   0 blocks new ARs; R keeps draining
//   s_ar_*               AR from the prefetcher (valid/ready/addr/len/id)
//   m_ar_*               registered AR towards DRAM
//   m_r_*                R from DRAM (valid/ready/data/last/id)
//   s_r_*                R towards the prefetcher (combinational copy)
//   outstandingCnt       bursts accepted and not yet completed
//   errorCode            sticky: [0] early last, [1] missing last,
//                        [2] R beat with nothing outstanding
module axi_rd_outstanding_limiter #(
   parameter int ADDR_BITS            = 64,
   parameter int BURST_LEN_WIDTH      = 8,
   parameter int TID_WIDTH            = 6,
   parameter int LOG_BLOCK_DATA_BYTES = 3,
   parameter int LOG_MAX_OUTSTANDING  = 2
) (
   input  logic                                   clk,
   input  logic                                   resetN,
   input  logic                                   en,
   // AR from prefetcher
   input  logic                                   s_ar_valid,
   output logic                                   s_ar_ready,
   input  logic [ADDR_BITS-1:0]                   s_ar_addr,
   input  logic [BURST_LEN_WIDTH-1:0]             s_ar_len,
   input  logic [TID_WIDTH-1:0]                   s_ar_id,
   // AR to DRAM
   output logic                                   m_ar_valid,
   input  logic                                   m_ar_ready,
   output logic [ADDR_BITS-1:0]                   m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0]             m_ar_len,
   output logic [TID_WIDTH-1:0]                   m_ar_id,
   // R from DRAM
   input  logic                                   m_r_valid,
   output logic                                   m_r_ready,
   input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   m_r_data,
   input  logic                                   m_r_last,
   input  logic [TID_WIDTH-1:0]                   m_r_id,
   // R to prefetcher
   output logic                                   s_r_valid,
   input  logic                                   s_r_ready,
   output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   s_r_data,
   output logic                                   s_r_last,
   output logic [TID_WIDTH-1:0]                   s_r_id,
   // status
   output logic [LOG_MAX_OUTSTANDING:0]           outstandingCnt,
   output logic [2:0]                             errorCode
);

   localparam int CNT_W   = LOG_MAX_OUTSTANDING + 1;
   localparam int PTR_W   = LOG_MAX_OUTSTANDING;
   localparam int MAX_OUT = 1 << LOG_MAX_OUTSTANDING;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   // Holds ready low during reset and releases it on the first edge after.
   logic                       rst_done_reg;

   logic                       slice_full_reg, slice_full_next;
   logic [ADDR_BITS-1:0]       ar_addr_reg;
   logic [BURST_LEN_WIDTH-1:0] ar_len_reg;
   logic [TID_WIDTH-1:0]       ar_id_reg;

   logic [CNT_W-1:0]           out_cnt_reg, out_cnt_next;
   logic [BURST_LEN_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
   logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
   logic [2:0]                 err_reg, err_next;

   // Burst lengths in acceptance order; DRAM answers in order so the head
   // always describes the burst currently returning.
   logic [BURST_LEN_WIDTH-1:0] len_fifo [MAX_OUT];

   logic                       ar_hs, mar_hs, r_hs;
   logic                       fifo_empty, pop;
   logic [BURST_LEN_WIDTH-1:0] head_len;

   // ---------------------------------------------------------------- R path
   assign s_r_valid = m_r_valid;
   assign s_r_data  = m_r_data;
   assign s_r_last  = m_r_last;
   assign s_r_id    = m_r_id;
   assign m_r_ready = s_r_ready;

   // -------------------------------------------------------------- AR path
   assign s_ar_ready = rst_done_reg && en && (out_cnt_reg < MAX_CNT)
                       && (!slice_full_reg || m_ar_ready);
   assign ar_hs      = s_ar_valid && s_ar_ready;
   assign mar_hs     = slice_full_reg && m_ar_ready;
   assign r_hs       = m_r_valid && s_r_ready;

   assign m_ar_valid     = slice_full_reg;
   assign m_ar_addr      = ar_addr_reg;
   assign m_ar_len       = ar_len_reg;
   assign m_ar_id        = ar_id_reg;
   assign outstandingCnt = out_cnt_reg;
   assign errorCode      = err_reg;

   // The FIFO occupancy always equals the outstanding count: both move on
   // the same push (AR accept) and pop (burst completion) events.
   assign fifo_empty = (out_cnt_reg == '0);
   assign head_len   = len_fifo[rd_ptr_reg];

   // ------------------------------------------------------- beat checker
   always_comb begin
      pop           = 1'b0;
      beat_cnt_next = beat_cnt_reg;
      err_next      = err_reg;
      if (r_hs) begin
         if (fifo_empty) begin
            err_next[2] = 1'b1;
         end else if (m_r_last && (beat_cnt_reg < head_len)) begin
            err_next[0] = 1'b1;
            pop         = 1'b1;
         end else if (!m_r_last && (beat_cnt_reg == head_len)) begin
            // Burst considered complete even without last.
            err_next[1] = 1'b1;
            pop         = 1'b1;
         end else if (m_r_last) begin
            pop = 1'b1;
         end else begin
            beat_cnt_next = beat_cnt_reg + BURST_LEN_WIDTH'(1);
         end
         if (pop) begin
            beat_cnt_next = '0;
         end
      end
   end

   always_comb begin
      out_cnt_next = out_cnt_reg;
      case ({ar_hs, pop})
         2'b10:   out_cnt_next = out_cnt_reg + CNT_W'(1);
         2'b01:   out_cnt_next = out_cnt_reg - CNT_W'(1);
         default: out_cnt_next = out_cnt_reg;
      endcase
      wr_ptr_next     = ar_hs ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;
      rd_ptr_next     = pop   ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
      // A load wins over a drain in the same cycle (bypass-on-drain).
      slice_full_next = ar_hs ? 1'b1 : (mar_hs ? 1'b0 : slice_full_reg);
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rst_done_reg   <= 1'b0;
         slice_full_reg <= 1'b0;
         ar_addr_reg    <= '0;
         ar_len_reg     <= '0;
         ar_id_reg      <= '0;
         out_cnt_reg    <= '0;
         beat_cnt_reg   <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         err_reg        <= '0;
      end else begin
         rst_done_reg   <= 1'b1;
         slice_full_reg <= slice_full_next;
         if (ar_hs) begin
            ar_addr_reg <= s_ar_addr;
            ar_len_reg  <= s_ar_len;
            ar_id_reg   <= s_ar_id;
         end
         out_cnt_reg    <= out_cnt_next;
         beat_cnt_reg   <= beat_cnt_next;
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         err_reg        <= err_next;
      end
   end

   // Length storage carries no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         len_fifo[wr_ptr_reg] <= s_ar_len;
      end
   end

endmodule

// File: tb/tb_axi_rd_outstanding_limiter.sv
// Testbench for axi_rd_outstanding_limiter: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_axi_rd_outstanding_limiter;

   localparam int AW   = 64;
   localparam int LW   = 8;
   localparam int IW   = 6;
   localparam int DW   = 64;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          en = 1'b0;
   logic          s_ar_valid = 1'b0;
   logic          s_ar_ready;
   logic [AW-1:0] s_ar_addr = '0;
   logic [LW-1:0] s_ar_len = '0;
   logic [IW-1:0] s_ar_id = '0;
   logic          m_ar_valid;
   logic          m_ar_ready = 1'b0;
   logic [AW-1:0] m_ar_addr;
   logic [LW-1:0] m_ar_len;
   logic [IW-1:0] m_ar_id;
   logic          m_r_valid = 1'b0;
   logic          m_r_ready;
   logic [DW-1:0] m_r_data = '0;
   logic          m_r_last = 1'b0;
   logic [IW-1:0] m_r_id = '0;
   logic          s_r_valid;
   logic          s_r_ready = 1'b0;
   logic [DW-1:0] s_r_data;
   logic          s_r_last;
   logic [IW-1:0] s_r_id;
   logic [2:0]    outstandingCnt;
   logic [2:0]    errorCode;

   always #5 clk = ~clk;

   axi_rd_outstanding_limiter #(
      .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
      .LOG_BLOCK_DATA_BYTES(3), .LOG_MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .resetN(resetN), .en(en),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
      .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
      .m_r_last(m_r_last), .m_r_id(m_r_id),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
      .s_r_last(s_r_last), .s_r_id(s_r_id),
      .outstandingCnt(outstandingCnt), .errorCode(errorCode)
   );

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------ reference model
   int            exp_q[$];       // lengths of bursts in flight, oldest first
   int            exp_beat;       // beats already seen of the head burst
   logic [2:0]    exp_err;
   bit            exp_slice_v;
   logic [AW-1:0] exp_addr;
   logic [LW-1:0] exp_len;
   logic [IW-1:0] exp_id;
   bit            exp_rst_done;

   function automatic bit model_ar_ready();
      return exp_rst_done && en && (exp_q.size() < MAXO)
             && (!exp_slice_v || m_ar_ready);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      exp_beat     = 0;
      exp_err      = 3'b000;
      exp_slice_v  = 1'b0;
      exp_addr     = '0;
      exp_len      = '0;
      exp_id       = '0;
      exp_rst_done = 1'b0;
   endtask

   // Advance one clock and update the model from the inputs presented.
   task automatic tick();
      bit            ar_hs, mar_hs, r_hs, last, rst_ok;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic [IW-1:0] i;
      ar_hs  = s_ar_valid && model_ar_ready();
      mar_hs = exp_slice_v && m_ar_ready;
      r_hs   = m_r_valid && s_r_ready;
      last   = m_r_last;
      a = s_ar_addr; l = s_ar_len; i = s_ar_id;
      rst_ok = resetN;
      @(posedge clk);
      if (rst_ok) begin
         if (r_hs) begin
            if (exp_q.size() == 0) begin
               exp_err[2] = 1'b1;
               $display("R beat with nothing outstanding, errorCode now %b", exp_err);
            end else begin
               bit done = 1'b0;
               if (last && exp_beat < exp_q[0]) begin
                  exp_err[0] = 1'b1; done = 1'b1;
               end else if (!last && exp_beat == exp_q[0]) begin
                  exp_err[1] = 1'b1; done = 1'b1;
               end else if (last) begin
                  done = 1'b1;
               end
               if (done) begin
                  $display("R burst done len=%0d beats=%0d err=%b", exp_q[0], exp_beat + 1, exp_err);
                  void'(exp_q.pop_front());
                  exp_beat = 0;
               end else begin
                  exp_beat++;
               end
            end
         end
         if (mar_hs && !ar_hs) exp_slice_v = 1'b0;
         if (ar_hs) begin
            exp_slice_v = 1'b1;
            exp_addr = a; exp_len = l; exp_id = i;
            exp_q.push_back(int'(l));
            $display("AR accepted addr=%h len=%0d id=%0d inflight=%0d", a, l, i, exp_q.size());
         end
         exp_rst_done = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      s_ar_valid = 1'b0;
      m_r_valid  = 1'b0;
      m_r_last   = 1'b0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      model_clear();
      idle_inputs();
      #1;
      @(posedge clk);
      #1;
      resetN = 1'b1;
      tick();
   endtask

   // ------------------------------------------------------------- scenarios
   task automatic test_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
      resetN = 1'b0; model_clear();
      @(posedge clk); #2;
      checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL reset_ar_ready got %b want 0", s_ar_ready); end
      checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_m_ar_valid got %b want 0", m_ar_valid); end
      checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", outstandingCnt); end
      checks++; if (errorCode !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", errorCode); end
      checks++; if (m_ar_addr !== '0 || m_ar_len !== '0 || m_ar_id !== '0) begin errors++; $display("FAIL reset_payload got %h/%0d/%0d want 0", m_ar_addr, m_ar_len, m_ar_id); end
      resetN = 1'b1; #1;
      checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL release_ready_before_edge got %b want 0", s_ar_ready); end
      tick();
      checks++; if (s_ar_ready !== 1'b1) begin errors++; $display("FAIL release_ready_after_edge got %b want 1", s_ar_ready); end
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      do_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
      s_ar_valid = 1'b1; s_ar_addr = 64'h0eef; s_ar_len = 8'd0; s_ar_id = 6'd5;
      #1;
      checks++; if (s_ar_ready !== 1'b1) begin errors++; $display("FAIL single_ar_ready got %b want 1", s_ar_ready); end
      tick();
      s_ar_valid = 1'b0; #1;
      checks++; if (m_ar_valid !== 1'b1) begin errors++; $display("FAIL single_m_ar_valid got %b want 1", m_ar_valid); end
      checks++; if (m_ar_addr !== 64'h0eef || m_ar_len !== 8'd0 || m_ar_id !== 6'd5) begin errors++; $display("FAIL single_payload got %h/%0d/%0d want 0eef/0/5", m_ar_addr, m_ar_len, m_ar_id); end
      checks++; if (outstandingCnt !== 3'd1) begin errors++; $display("FAIL single_cnt_up got %0d want 1", outstandingCnt); end
      tick();
      checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL single_slice_drain got %b want 0", m_ar_valid); end
      d = {$urandom, $urandom};
      m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = d; m_r_id = 6'd5; #1;
      checks++; if (s_r_valid !== 1'b1 || s_r_data !== d || s_r_last !== 1'b1 || s_r_id !== 6'd5) begin errors++; $display("FAIL single_r_pass got %b/%h/%b/%0d want 1/%h/1/5", s_r_valid, s_r_data, s_r_last, s_r_id, d); end
      checks++; if (m_r_ready !== 1'b1) begin errors++; $display("FAIL single_r_ready got %b want 1", m_r_ready); end
      tick();
      idle_inputs(); #1;
      checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL single_cnt_down got %0d want 0", outstandingCnt); end
      checks++; if (errorCode !== 3'b000) begin errors++; $display("FAIL single_err got %b want 000", errorCode); end
   endtask

   task automatic test_cap();
      int acc = 0;
      do_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b0;
      s_ar_len = 8'd0;
      for (int k = 0; k < 6; k++) begin
         s_ar_valid = 1'b1; s_ar_addr = 64'(k * 64); s_ar_id = 6'(k);
         #1;
         if (s_ar_ready === 1'b1) acc++;
         tick();
      end
      s_ar_valid = 1'b0; #1;
      checks++; if (acc !== 4) begin errors++; $display("FAIL cap_accepted got %0d want 4", acc); end
      checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL cap_ready got %b want 0", s_ar_ready); end
      checks++; if (outstandingCnt !== 3'd4) begin errors++; $display("FAIL cap_cnt got %0d want 4", outstandingCnt); end
      m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1; #1;
      checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL cap_ready_same_cycle got %b want 0", s_ar_ready); end
      tick();
      idle_inputs(); s_r_ready = 1'b0; #1;
      checks++; if (s_ar_ready !== 1'b1 || outstandingCnt !== 3'd3) begin errors++; $display("FAIL cap_reopen got ready=%b cnt=%0d want 1/3", s_ar_ready, outstandingCnt); end
      for (int k = 0; k < 3; k++) begin
         m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
         tick();
      end
      idle_inputs(); #1;
      checks++; if (outstandingCnt !== 3'd0 || errorCode !== 3'b000) begin errors++; $display("FAIL cap_drain got cnt=%0d err=%b want 0/000", outstandingCnt, errorCode); end
   endtask

   task automatic test_early_last();
      do_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
      s_ar_valid = 1'b1; s_ar_len = 8'd3; s_ar_id = 6'd9; s_ar_addr = 64'h1000;
      tick();
      s_ar_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_r_valid = 1'b1; m_r_last = (k == 2); m_r_data = 64'(k);
         tick();
      end
      idle_inputs(); #1;
      checks++; if (errorCode !== 3'b001) begin errors++; $display("FAIL early_last_err got %b want 001", errorCode); end
      checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL early_last_cnt got %0d want 0", outstandingCnt); end
   endtask

   task automatic test_missing_last();
      do_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
      s_ar_valid = 1'b1; s_ar_len = 8'd1; s_ar_id = 6'd1;
      tick();
      s_ar_len = 8'd2; s_ar_id = 6'd2;
      tick();
      s_ar_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_r_valid = 1'b1; m_r_last = 1'b0;
         tick();
      end
      idle_inputs(); #1;
      checks++; if (errorCode !== 3'b010 || outstandingCnt !== 3'd1) begin errors++; $display("FAIL missing_last got err=%b cnt=%0d want 010/1", errorCode, outstandingCnt); end
      for (int k = 0; k < 3; k++) begin
         m_r_valid = 1'b1; m_r_last = (k == 2);
         tick();
      end
      idle_inputs(); #1;
      checks++; if (errorCode !== 3'b010 || outstandingCnt !== 3'd0) begin errors++; $display("FAIL missing_last_next got err=%b cnt=%0d want 010/0", errorCode, outstandingCnt); end
   endtask

   task automatic test_orphan_r();
      do_reset();
      en = 1'b1; s_r_ready = 1'b1;
      m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 64'hdead_beef_0000_0001; #1;
      checks++; if (m_r_ready !== 1'b1 || s_r_valid !== 1'b1) begin errors++; $display("FAIL orphan_pass got ready=%b valid=%b want 1/1", m_r_ready, s_r_valid); end
      tick();
      idle_inputs(); #1;
      checks++; if (errorCode !== 3'b100 || outstandingCnt !== 3'd0) begin errors++; $display("FAIL orphan_err got err=%b cnt=%0d want 100/0", errorCode, outstandingCnt); end
      // reset in the middle of a burst drops state at once
      do_reset();
      m_ar_ready = 1'b1;
      s_ar_valid = 1'b1; s_ar_len = 8'd3;
      tick();
      s_ar_valid = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b0;
      tick();
      idle_inputs();
      resetN = 1'b0; model_clear(); #1;
      checks++; if (outstandingCnt !== 3'd0 || m_ar_valid !== 1'b0) begin errors++; $display("FAIL async_reset got cnt=%0d mv=%b want 0/0", outstandingCnt, m_ar_valid); end
      @(posedge clk); #1;
      resetN = 1'b1;
      tick();
      m_r_valid = 1'b1; m_r_last = 1'b0;
      tick();
      idle_inputs(); #1;
      checks++; if (errorCode !== 3'b100) begin errors++; $display("FAIL reset_mid_burst_err got %b want 100", errorCode); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      en = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
      s_ar_valid = 1'b1; s_ar_len = 8'd0;
      tick();
      s_ar_valid = 1'b0;
      tick();
      s_ar_valid = 1'b1; m_r_valid = 1'b1; m_r_last = 1'b1; #1;
      checks++; if (s_ar_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", s_ar_ready); end
      tick();
      idle_inputs(); #1;
      checks++; if (outstandingCnt !== 3'd1) begin errors++; $display("FAIL b2b_cnt got %0d want 1", outstandingCnt); end
      en = 1'b0; s_ar_valid = 1'b1; m_r_valid = 1'b1; m_r_last = 1'b1; #1;
      checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL en_off_ready got %b want 0", s_ar_ready); end
      tick();
      m_r_valid = 1'b0;
      tick();
      s_ar_valid = 1'b0; #1;
      checks++; if (outstandingCnt !== 3'd0 || s_ar_ready !== 1'b0 || errorCode !== 3'b000) begin errors++; $display("FAIL en_off_drain got cnt=%0d ready=%b err=%b want 0/0/000", outstandingCnt, s_ar_ready, errorCode); end
      en = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en         = ($urandom_range(0, 7) != 0);
         s_ar_valid = $urandom_range(0, 1);
         s_ar_addr  = {$urandom, $urandom};
         s_ar_len   = LW'($urandom_range(0, 3));
         s_ar_id    = IW'($urandom);
         m_ar_ready = ($urandom_range(0, 3) != 0);
         m_r_valid  = ($urandom_range(0, 2) != 0);
         s_r_ready  = ($urandom_range(0, 3) != 0);
         m_r_data   = {$urandom, $urandom};
         m_r_id     = IW'($urandom);
         if (exp_q.size() > 0 && exp_beat == exp_q[0])
            m_r_last = ($urandom_range(0, 7) != 0);
         else
            m_r_last = ($urandom_range(0, 7) == 0);
         #1;
         checks++; if (s_ar_ready !== model_ar_ready()) begin errors++; $display("FAIL rnd_ar_ready cyc %0d got %b want %b", c, s_ar_ready, model_ar_ready()); end
         checks++; if (m_ar_valid !== exp_slice_v) begin errors++; $display("FAIL rnd_m_ar_valid cyc %0d got %b want %b", c, m_ar_valid, exp_slice_v); end
         checks++; if (m_ar_addr !== exp_addr || m_ar_len !== exp_len || m_ar_id !== exp_id) begin errors++; $display("FAIL rnd_payload cyc %0d got %h/%0d/%0d want %h/%0d/%0d", c, m_ar_addr, m_ar_len, m_ar_id, exp_addr, exp_len, exp_id); end
         checks++; if (int'(outstandingCnt) !== exp_q.size()) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, outstandingCnt, exp_q.size()); end
         checks++; if (errorCode !== exp_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", c, errorCode, exp_err); end
         checks++; if (s_r_valid !== m_r_valid || s_r_data !== m_r_data || s_r_last !== m_r_last || s_r_id !== m_r_id || m_r_ready !== s_r_ready) begin errors++; $display("FAIL rnd_r_pass cyc %0d got v%b d%h l%b i%0d r%b", c, s_r_valid, s_r_data, s_r_last, s_r_id, m_r_ready); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_cap();
      test_early_last();
      test_missing_last();
      test_orphan_r();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
